ov7670_capture: RTL and testbench

- Captures the OV7670 parallel video stream (8-bit bus, two bytes per RGB565 pixel) in the camera pixel-clock domain.
- Assembles 16-bit pixels and generates a linear frame-buffer write address plus x/y coordinates.
- Signals end of frame.
- Sits between the camera pins and the dual-clock frame-buffer BRAM write port.

---
 rtl/ov7670_capture_if.sv | 26 ++
 rtl/ov7670_capture.sv | 102 ++++++++++
 tb/tb_ov7670_capture.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_capture_if.sv
// ov7670_capture_if: camera pins in, frame-buffer write side out.
// Carries ds_pixel only when CAPTURE_RGB444_EN is defined.
interface ov7670_capture_if #(parameter int ADDR_W = 19);
    logic              vsync;
    logic              href;
    logic [7:0]        p_data;
    logic [15:0]       pixel_data;
    logic              pixel_valid;
    logic [ADDR_W-1:0] pixel_addr;
    logic [9:0]        pixel_x;
    logic [8:0]        pixel_y;
    logic              frame_done;
    logic              frame_err;
`ifdef CAPTURE_RGB444_EN
    logic [11:0]       ds_pixel;
    modport master (input vsync, href, p_data,
                    output pixel_data, pixel_valid, pixel_addr, pixel_x, pixel_y, frame_done, frame_err, ds_pixel);
    modport slave  (output vsync, href, p_data,
                    input pixel_data, pixel_valid, pixel_addr, pixel_x, pixel_y, frame_done, frame_err, ds_pixel);
`else
    modport master (input vsync, href, p_data,
                    output pixel_data, pixel_valid, pixel_addr, pixel_x, pixel_y, frame_done, frame_err);
    modport slave  (output vsync, href, p_data,
                    input pixel_data, pixel_valid, pixel_addr, pixel_x, pixel_y, frame_done, frame_err);
`endif
endinterface

// File: rtl/ov7670_capture.sv
// ov7670_capture: OV7670 byte stream to RGB565 pixels with linear address, x/y and end-of-frame status.
// Optional CAPTURE_RGB444_EN adds the registered ds_pixel RGB444 output.
module ov7670_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic             clk,
    input  logic             rst,
    ov7670_capture_if.master cam
);
    localparam logic [ADDR_W-1:0] N_PIX = ADDR_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [9:0]        X_MAX = 10'(H_ACTIVE);
    localparam logic [8:0]        Y_MAX = 9'(V_ACTIVE);

    typedef enum logic [1:0] {WAIT_SYNC, WAIT_START, CAPTURE} state_t;

    state_t            state;
    logic              phase;
    logic              href_q;
    logic              ovf;
    logic [7:0]        hi;
    logic [9:0]        x;
    logic [8:0]        y;
    logic [ADDR_W-1:0] addr;
    logic              fits;

    always_comb fits = x < X_MAX && y < Y_MAX && addr < N_PIX;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= WAIT_SYNC;
            phase           <= 1'b0;
            href_q          <= 1'b0;
            ovf             <= 1'b0;
            hi              <= '0;
            x               <= '0;
            y               <= '0;
            addr            <= '0;
            cam.pixel_data  <= '0;
            cam.pixel_valid <= 1'b0;
            cam.pixel_addr  <= '0;
            cam.pixel_x     <= '0;
            cam.pixel_y     <= '0;
            cam.frame_done  <= 1'b0;
            cam.frame_err   <= 1'b0;
`ifdef CAPTURE_RGB444_EN
            cam.ds_pixel    <= '0;
`endif
        end else begin
            href_q          <= cam.href;
            cam.pixel_valid <= 1'b0;
            cam.frame_done  <= 1'b0;
            cam.frame_err   <= 1'b0;
            // vsync high always leads into WAIT_START, so the per-frame state is cleared here
            if (cam.vsync) begin
                phase <= 1'b0;
                ovf   <= 1'b0;
                x     <= '0;
                y     <= '0;
                addr  <= '0;
            end
            case (state)
                WAIT_SYNC:  state <= cam.vsync ? WAIT_START : WAIT_SYNC;
                WAIT_START: state <= cam.vsync ? WAIT_START : CAPTURE;
                CAPTURE: begin
                    if (cam.vsync) begin
                        state          <= WAIT_START;
                        cam.frame_done <= 1'b1;
                        cam.frame_err  <= ovf || addr != N_PIX;
                    end else if (cam.href) begin
                        phase <= ~phase;
                        if (!phase) begin
                            hi <= cam.p_data;
                        end else if (fits) begin
                            cam.pixel_valid <= 1'b1;
                            cam.pixel_data  <= {hi, cam.p_data};
                            cam.pixel_addr  <= addr;
                            cam.pixel_x     <= x;
                            cam.pixel_y     <= y;
`ifdef CAPTURE_RGB444_EN
                            cam.ds_pixel    <= {hi[7:4], hi[2:0], cam.p_data[7], cam.p_data[4:1]};
`endif
                            x    <= x + 10'd1;
                            addr <= addr + ADDR_W'(1);
                        end else begin
                            ovf <= 1'b1;
                        end
                    end else begin
                        phase <= 1'b0;
                        // x is nonzero only if this line emitted a pixel
                        if (href_q && x != '0) begin
                            x <= '0;
                            y <= y + 9'd1;
                        end
                    end
                end
                default: state <= WAIT_SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: random and directed camera streams checked against a line/pixel-level model.
// Build with CAPTURE_RGB444_EN to also check ds_pixel.
module tb_ov7670_capture;
    localparam int H = 16, V = 6, AW = 7, NPIX = H * V;

    typedef struct {logic [15:0] d; int a; int x; int y; int c; logic [11:0] ds;} px_t;
    typedef struct {bit err; int c;} fr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ov7670_capture_if #(.ADDR_W(AW)) cam ();
    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .cam(cam));

    px_t  px_q[$], px_log[$];
    fr_t  fr_q[$];
    bit   fr_log[$];
    px_t  e;
    fr_t  f;
    bit   exp_pv, exp_fd;
    int   checks = 0, failures = 0, cyc = 0;
    bit   cap = 0, ovf = 0;
    int   mx = 0, my = 0, ma = 0, mode = 0, bseq = 0;
    logic [7:0] pat[4];
    logic [11:0] ds_now;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

`ifdef CAPTURE_RGB444_EN
    function automatic logic [11:0] rgb444(logic [15:0] p);
        return {p[15:12], p[10:7], p[4:1]};
    endfunction
`endif

    always @(negedge clk) begin
`ifdef CAPTURE_RGB444_EN
        ds_now = cam.ds_pixel;
`else
        ds_now = '0;
`endif
        exp_pv = px_q.size() > 0 && px_q[0].c == cyc;
        chk("pixel_valid", {31'd0, cam.pixel_valid}, {31'd0, exp_pv});
        if (cam.pixel_valid)
            px_log.push_back('{d: cam.pixel_data, a: int'(cam.pixel_addr), x: int'(cam.pixel_x),
                               y: int'(cam.pixel_y), c: cyc, ds: ds_now});
        if (exp_pv) begin
            e = px_q.pop_front();
            if (cam.pixel_valid) begin
                chk("pixel_data", {16'd0, cam.pixel_data}, {16'd0, e.d});
                chk("pixel_addr", 32'(cam.pixel_addr), e.a);
                chk("pixel_x", 32'(cam.pixel_x), e.x);
                chk("pixel_y", 32'(cam.pixel_y), e.y);
`ifdef CAPTURE_RGB444_EN
                chk("ds_pixel", {20'd0, cam.ds_pixel}, {20'd0, rgb444(e.d)});
`endif
            end
        end
        exp_fd = fr_q.size() > 0 && fr_q[0].c == cyc;
        chk("frame_done", {31'd0, cam.frame_done}, {31'd0, exp_fd});
        if (cam.frame_done) fr_log.push_back(cam.frame_err);
        if (exp_fd) begin
            f = fr_q.pop_front();
            chk("frame_err", {31'd0, cam.frame_err}, {31'd0, f.err});
        end else begin
            chk("frame_err_idle", {31'd0, cam.frame_err}, 32'd0);
        end
    end

    task automatic drive(bit v, bit h, logic [7:0] d);
        @(negedge clk);
        cam.vsync  = v;
        cam.href   = h;
        cam.p_data = d;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_data"}, {16'd0, cam.pixel_data}, 32'd0);
        chk({tag, "_valid"}, {31'd0, cam.pixel_valid}, 32'd0);
        chk({tag, "_addr"}, 32'(cam.pixel_addr), 32'd0);
        chk({tag, "_x"}, 32'(cam.pixel_x), 32'd0);
        chk({tag, "_y"}, 32'(cam.pixel_y), 32'd0);
        chk({tag, "_done"}, {31'd0, cam.frame_done}, 32'd0);
        chk({tag, "_err"}, {31'd0, cam.frame_err}, 32'd0);
    endtask

    task automatic frame_end(bit h, int hold);
        drive(1'b1, h, 8'($urandom));
        if (cap) fr_q.push_back('{err: ovf || ma != NPIX, c: cyc + 1});
        repeat (hold - 1) drive(1'b1, 1'b0, 8'd0);
        drive(1'b0, 1'b0, 8'd0);
        cap = 1; ovf = 0; mx = 0; my = 0; ma = 0;
    endtask

    task automatic line(int n, int gap, bit vs_end);
        logic [7:0] b0 = '0, d;
        int em = 0;
        for (int j = 0; j < n; j++) begin
            d = (mode == 1) ? 8'(bseq) : (mode == 2) ? pat[j % 4] : 8'($urandom);
            bseq++;
            drive(1'b0, 1'b1, d);
            if (j % 2 == 0) b0 = d;
            else if (cap) begin
                if (mx < H && my < V && ma < NPIX) begin
                    px_q.push_back('{d: {b0, d}, a: ma, x: mx, y: my, c: cyc + 1, ds: 12'd0});
                    mx++; ma++; em++;
                end else ovf = 1;
            end
        end
        if (vs_end) frame_end(1'b1, 2);
        else begin
            if (em > 0) begin mx = 0; my++; end
            repeat (gap) drive(1'b0, 1'b0, 8'($urandom));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("midreset");
        rst = 1'b0;
        cap = 0; ovf = 0; mx = 0; my = 0; ma = 0;
    endtask

    initial begin
        automatic logic [15:0] e_d[4] = '{16'hF800, 16'h07E0, 16'hF800, 16'h07E0};
        automatic int e_x[4] = '{0, 1, 0, 1};
        automatic int e_y[4] = '{0, 0, 1, 1};
        int b, nl, n;
        bit vs;
        cam.vsync = 1'b0; cam.href = 1'b0; cam.p_data = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        // stream already running after reset: nothing may be captured
        mode = 0;
        line(8, 2, 0);
        line(6, 1, 0);
        repeat (2) @(negedge clk);
        chk("no_pixels_before_sync", px_log.size(), 0);
        frame_end(1'b0, 3);
        // two short lines of red/green pixels
        mode = 2;
        pat = '{8'hF8, 8'h00, 8'h07, 8'hE0};
        line(4, 2, 0);
        line(4, 2, 0);
        frame_end(1'b0, 2);
        repeat (2) @(negedge clk);
        chk("t1_count", px_log.size(), 4);
        if (px_log.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                chk("t1_data", {16'd0, px_log[i].d}, {16'd0, e_d[i]});
                chk("t1_addr", px_log[i].a, i);
                chk("t1_x", px_log[i].x, e_x[i]);
                chk("t1_y", px_log[i].y, e_y[i]);
            end
        chk("t1_frames", fr_log.size(), 1);
        if (fr_log.size() >= 1) chk("t1_err", {31'd0, fr_log[0]}, 32'd1);
        // full frame of incrementing bytes
        mode = 1; bseq = 0; b = px_log.size();
        for (int l = 0; l < V; l++) line(2 * H, 1, 0);
        frame_end(1'b0, 2);
        repeat (2) @(negedge clk);
        chk("full_count", px_log.size() - b, NPIX);
        if (px_log.size() > 0) begin
            chk("full_last_addr", px_log[$].a, NPIX - 1);
            chk("full_last_x", px_log[$].x, H - 1);
            chk("full_last_y", px_log[$].y, V - 1);
            chk("full_last_data", {16'd0, px_log[$].d}, 32'h0000BEBF);
        end
        if (fr_log.size() > 0) chk("full_err", {31'd0, fr_log[$]}, 32'd0);
        // odd line: trailing byte dropped, next line restarts at x=0
        mode = 0; b = px_log.size();
        line(5, 1, 0);
        line(4, 1, 0);
        repeat (2) @(negedge clk);
        chk("odd_count", px_log.size() - b, 4);
        if (px_log.size() >= b + 3) begin
            chk("odd_next_x", px_log[b + 2].x, 0);
            chk("odd_next_y", px_log[b + 2].y, 1);
        end
        // second byte on the last cycle, vsync rising with href high
        line(6, 0, 1);
`ifdef CAPTURE_RGB444_EN
        mode = 2; b = px_log.size();
        pat = '{8'hFF, 8'hFF, 8'hF8, 8'h00};
        line(4, 1, 0);
        repeat (2) @(negedge clk);
        if (px_log.size() >= b + 2) begin
            chk("ds_white", {20'd0, px_log[b].ds}, 32'h00000FFF);
            chk("ds_red", {20'd0, px_log[b + 1].ds}, 32'h00000F00);
        end
        frame_end(1'b0, 2);
        mode = 0;
`endif
        // random frames, including over-long lines and too many lines
        for (int fr = 0; fr < 25; fr++) begin
            nl = (fr % 5 == 0) ? V : $urandom_range(0, V + 2);
            vs = 0;
            for (int l = 0; l < nl; l++) begin
                n = (fr % 5 == 0) ? 2 * H : $urandom_range(0, 2 * H + 3);
                vs = (l == nl - 1) && ($urandom_range(0, 3) == 0);
                line(n, $urandom_range(1, 3), vs);
            end
            if (!vs) frame_end(1'b0, $urandom_range(1, 3));
        end
        // reset in the middle of a line, then recapture from address 0
        line(6, 0, 0);
        do_reset();
        b = px_log.size();
        line(8, 1, 0);
        repeat (2) @(negedge clk);
        chk("post_reset_silent", px_log.size() - b, 0);
        frame_end(1'b0, 2);
        mode = 1; bseq = 0; b = px_log.size();
        for (int l = 0; l < V; l++) line(2 * H, 1, 0);
        frame_end(1'b0, 2);
        repeat (3) @(negedge clk);
        if (px_log.size() > b) chk("recap_first_addr", px_log[b].a, 0);
        chk("recap_count", px_log.size() - b, NPIX);
        if (fr_log.size() > 0) chk("recap_err", {31'd0, fr_log[$]}, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
